// File: rtl/nv_ram_fifo_pkg.sv
// Shared constants and types for the 32x272 RAM-backed FIFO controller and its output skid.
package nv_ram_fifo_pkg;

    localparam int DEPTH      = 32;
    localparam int AW         = 5;
    localparam int DW         = 272;
    localparam int SKID_DEPTH = 2;
    localparam int CNT_W      = 6;

    typedef logic [AW-1:0]    ptr_t;
    typedef logic [DW-1:0]    data_t;
    typedef logic [CNT_W-1:0] count_t;
    typedef logic [1:0]       skid_cnt_t;

endpackage

// File: rtl/nv_ram_fifo_skid2.sv
// Two-entry output skid: captures RAM read data and presents the head entry to the consumer.
module nv_ram_fifo_skid2
    import nv_ram_fifo_pkg::*;
(
    input  logic      clk,
    input  logic      rst,
    input  logic      push,
    input  data_t     din,
    input  logic      pop,
    output logic      valid,
    output data_t     dout,
    output skid_cnt_t cnt
);

    data_t slot [SKID_DEPTH];
    logic  wr_idx;

    assign valid = (cnt != '0);
    assign dout  = slot[0];

    // Tail slot as seen after this cycle's pop has shifted the queue.
    assign wr_idx = (cnt == 2'd2) || ((cnt == 2'd1) && !pop);

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            cnt <= '0;
        end else begin
            cnt <= cnt + skid_cnt_t'(push) - skid_cnt_t'(pop);
        end
    end

    // NOTE: payload slots are not reset; cnt alone says which slots hold valid data.
    always_ff @(posedge clk) begin
        if (pop && (cnt == 2'd2)) begin
            slot[0] <= slot[1];
        end
        if (push) begin
            slot[wr_idx] <= din;
        end
    end

`ifndef SYNTHESIS
    a_cnt_range: assert property (@(posedge clk) disable iff (rst)
        cnt <= skid_cnt_t'(SKID_DEPTH));
    a_no_overflow: assert property (@(posedge clk) disable iff (rst)
        push |-> ((cnt < skid_cnt_t'(SKID_DEPTH)) || pop));
    a_no_underflow: assert property (@(posedge clk) disable iff (rst)
        pop |-> valid);
`endif

endmodule

// File: rtl/nv_ram_rws_32x272_fifo_ctrl.sv
// Runs an external 32x272 synchronous RAM as a valid/ready FIFO; a 2-entry skid hides the read latency.
module nv_ram_rws_32x272_fifo_ctrl
    import nv_ram_fifo_pkg::*;
(
    input  logic              nvdla_core_clk,
    input  logic              nvdla_core_rst,
    input  logic              wr_pvld,
    output logic              wr_prdy,
    input  logic [DW-1:0]     wr_pd,
    output logic              rd_pvld,
    input  logic              rd_prdy,
    output logic [DW-1:0]     rd_pd,
    output logic [CNT_W-1:0]  fifo_count,
    output logic [AW-1:0]     ram_wa,
    output logic              ram_we,
    output logic [DW-1:0]     ram_di,
    output logic [AW-1:0]     ram_ra,
    output logic              ram_re,
    input  logic [DW-1:0]     ram_dout,
    input  logic [31:0]       pwrbus_ram_pd
);

    ptr_t      wr_ptr;
    ptr_t      rd_ptr;
    count_t    ram_used;
    count_t    ram_used_nxt;
    count_t    skid_cnt_nxt;
    skid_cnt_t skid_cnt;
    logic      inflight;
    logic      push;
    logic      pop;
    logic      issue;
    logic      capture;
    logic      has_unissued;
    logic      skid_room;
    logic      unused_pwrbus;

    // The RAM's power bus is wired to the RAM by the parent; nothing here consumes it.
    assign unused_pwrbus = ^pwrbus_ram_pd;

    assign wr_prdy = (ram_used < count_t'(DEPTH));
    assign push    = wr_pvld && wr_prdy && !nvdla_core_rst;
    assign pop     = rd_pvld && rd_prdy;
    assign capture = inflight;

    // The entry in flight stays in ram_used until captured, so its slot cannot be rewritten early.
    assign has_unissued = (ram_used > count_t'(inflight));
    assign skid_room    = (count_t'(skid_cnt) + count_t'(inflight))
                        < (count_t'(SKID_DEPTH) + count_t'(pop));
    assign issue        = has_unissued && skid_room;

    assign ram_used_nxt = ram_used + count_t'(push) - count_t'(capture);
    assign skid_cnt_nxt = count_t'(skid_cnt) + count_t'(capture) - count_t'(pop);

    assign ram_we = push;
    assign ram_wa = wr_ptr;
    assign ram_di = wr_pd;
    assign ram_re = issue;
    assign ram_ra = rd_ptr;

    // NOTE: all state here uses <= so every flop samples the values from before the edge.
    always_ff @(posedge nvdla_core_clk or posedge nvdla_core_rst) begin
        if (nvdla_core_rst) begin
            wr_ptr     <= '0;
            rd_ptr     <= '0;
            ram_used   <= '0;
            inflight   <= 1'b0;
            fifo_count <= '0;
        end else begin
            if (push) begin
                wr_ptr <= wr_ptr + ptr_t'(1);
            end
            if (issue) begin
                rd_ptr <= rd_ptr + ptr_t'(1);
            end
            ram_used   <= ram_used_nxt;
            inflight   <= issue;
            fifo_count <= ram_used_nxt + skid_cnt_nxt;
        end
    end

    nv_ram_fifo_skid2 u_skid (
        .clk   (nvdla_core_clk),
        .rst   (nvdla_core_rst),
        .push  (capture),
        .din   (ram_dout),
        .pop   (pop),
        .valid (rd_pvld),
        .dout  (rd_pd),
        .cnt   (skid_cnt)
    );

`ifndef SYNTHESIS
    a_push_ready: assert property (@(posedge nvdla_core_clk) disable iff (nvdla_core_rst)
        ram_we |-> wr_prdy);
    a_used_range: assert property (@(posedge nvdla_core_clk) disable iff (nvdla_core_rst)
        ram_used <= count_t'(DEPTH));
    a_no_rw_same: assert property (@(posedge nvdla_core_clk) disable iff (nvdla_core_rst)
        !(ram_re && ram_we && (ram_ra == ram_wa)));
    a_no_wr_inflight: assert property (@(posedge nvdla_core_clk) disable iff (nvdla_core_rst)
        (inflight && ram_we) |-> (ram_wa != (rd_ptr - ptr_t'(1))));
`endif

endmodule

// File: tb/tb_nv_ram_rws_32x272_fifo_ctrl.sv
// Directed and random bench for the RAM FIFO controller, with a behavioural RAM and a queue model.
module tb_nv_ram_rws_32x272_fifo_ctrl;
    import nv_ram_fifo_pkg::*;

    typedef logic [DW-1:0] pd_t;

    logic             clk;
    logic             rst;
    logic             wr_pvld;
    logic             wr_prdy;
    pd_t              wr_pd;
    logic             rd_pvld;
    logic             rd_prdy;
    pd_t              rd_pd;
    logic [CNT_W-1:0] fifo_count;
    logic [AW-1:0]    ram_wa;
    logic             ram_we;
    pd_t              ram_di;
    logic [AW-1:0]    ram_ra;
    logic             ram_re;
    pd_t              ram_dout;
    logic [31:0]      pwrbus_ram_pd;

    pd_t mem [DEPTH];
    pd_t q[$];
    pd_t last_pop;
    int  pops;
    int  errors;
    int  checks;

    nv_ram_rws_32x272_fifo_ctrl dut (
        .nvdla_core_clk (clk),
        .nvdla_core_rst (rst),
        .wr_pvld        (wr_pvld),
        .wr_prdy        (wr_prdy),
        .wr_pd          (wr_pd),
        .rd_pvld        (rd_pvld),
        .rd_prdy        (rd_prdy),
        .rd_pd          (rd_pd),
        .fifo_count     (fifo_count),
        .ram_wa         (ram_wa),
        .ram_we         (ram_we),
        .ram_di         (ram_di),
        .ram_ra         (ram_ra),
        .ram_re         (ram_re),
        .ram_dout       (ram_dout),
        .pwrbus_ram_pd  (pwrbus_ram_pd)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Synchronous RAM with one-cycle read latency.
    always @(posedge clk) begin
        if (ram_we) mem[ram_wa] <= ram_di;
        if (ram_re) ram_dout <= mem[ram_ra];
    end

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog expired");
    end

    task automatic check(input string tag, input pd_t observed, input pd_t expected);
        checks++;
        assert (observed === expected) else begin
            errors++;
            $error("FAIL %s: observed=%0h expected=%0h", tag, observed, expected);
        end
    endtask

    function automatic pd_t rand_pd();
        logic [287:0] t;
        for (int i = 0; i < 9; i++) t[i*32 +: 32] = $urandom();
        return t[DW-1:0];
    endfunction

    task automatic drive(input logic wv, input pd_t wd, input logic rr);
        wr_pvld = wv;
        wr_pd   = wd;
        rd_prdy = rr;
    endtask

    // One clock cycle: record handshakes against the model, then check the held count.
    task automatic tick();
        #1;
        if (rd_pvld && rd_prdy) begin
            check("pop_while_empty", pd_t'(q.size() == 0), pd_t'(1'b0));
            if (q.size() > 0) begin
                check("pop_data", rd_pd, q[0]);
                last_pop = q.pop_front();
                pops++;
            end
        end
        if (wr_pvld && wr_prdy) q.push_back(wr_pd);
        @(posedge clk);
        @(negedge clk);
        check("fifo_count", pd_t'(fifo_count), pd_t'(q.size()));
        if (q.size() < DEPTH) check("wr_prdy_space", pd_t'(wr_prdy), pd_t'(1'b1));
    endtask

    task automatic drain();
        int n;
        n = 0;
        drive(1'b0, '0, 1'b1);
        while ((q.size() != 0) && (n < 200)) begin
            tick();
            n++;
        end
        check("drain_empty", pd_t'(fifo_count), pd_t'(0));
    endtask

    initial begin
        pd_t a5;
        pd_t pa, pb, pc, pd;
        int  pops_at;
        int  pops0;
        int  n;
        logic [CNT_W-1:0] cnt_at;

        errors        = 0;
        checks        = 0;
        pops          = 0;
        last_pop      = '0;
        pwrbus_ram_pd = 32'h0;
        rst           = 1'b1;
        drive(1'b0, '0, 1'b0);

        // Reset state, then idle.
        @(negedge clk);
        check("rst_wr_prdy", pd_t'(wr_prdy), pd_t'(1'b1));
        check("rst_rd_pvld", pd_t'(rd_pvld), pd_t'(1'b0));
        check("rst_count", pd_t'(fifo_count), pd_t'(0));
        repeat (2) @(negedge clk);
        rst = 1'b0;
        for (int i = 0; i < 10; i++) begin
            check("idle_wr_prdy", pd_t'(wr_prdy), pd_t'(1'b1));
            check("idle_rd_pvld", pd_t'(rd_pvld), pd_t'(1'b0));
            check("idle_ram_we", pd_t'(ram_we), pd_t'(1'b0));
            check("idle_ram_re", pd_t'(ram_re), pd_t'(1'b0));
            tick();
        end

        // Single push: data appears three cycles later.
        a5 = {34{8'hA5}};
        drive(1'b1, a5, 1'b1);
        tick();
        drive(1'b0, '0, 1'b1);
        check("single_issue", pd_t'(ram_re), pd_t'(1'b1));
        check("single_t1_pvld", pd_t'(rd_pvld), pd_t'(1'b0));
        tick();
        check("single_t2_pvld", pd_t'(rd_pvld), pd_t'(1'b0));
        tick();
        check("single_t3_pvld", pd_t'(rd_pvld), pd_t'(1'b1));
        check("single_t3_pd", rd_pd, a5);
        tick();
        check("single_drained", pd_t'(rd_pvld), pd_t'(1'b0));

        // Fill to 34 with no pops, then drain in order across the pointer wrap.
        for (int i = 0; i < 34; i++) begin
            check("fill_wr_prdy", pd_t'(wr_prdy), pd_t'(1'b1));
            drive(1'b1, pd_t'(i), 1'b0);
            tick();
        end
        check("full_wr_prdy", pd_t'(wr_prdy), pd_t'(1'b0));
        check("full_count", pd_t'(fifo_count), pd_t'(34));
        check("full_rd_pvld", pd_t'(rd_pvld), pd_t'(1'b1));
        drive(1'b1, rand_pd(), 1'b0);
        tick();
        pops0 = pops;
        drain();
        check("fill_pop_total", pd_t'(pops - pops0), pd_t'(34));
        check("fill_last", last_pop, pd_t'(33));

        // Continuous streaming: one pop per cycle once primed, occupancy steady.
        pops_at = 0;
        cnt_at  = '0;
        for (int c = 0; c < 200; c++) begin
            drive(1'b1, rand_pd(), 1'b1);
            if (c == 10) begin
                pops_at = pops;
                cnt_at  = fifo_count;
            end
            tick();
        end
        check("stream_pop_rate", pd_t'(pops - pops_at), pd_t'(190));
        check("stream_count_stable", pd_t'(fifo_count), pd_t'(cnt_at));
        drain();

        // Random traffic.
        for (int c = 0; c < 10000; c++) begin
            drive(1'($urandom_range(0, 1)), rand_pd(), 1'($urandom_range(0, 1)));
            tick();
        end
        drain();

        // Asynchronous reset while a read is in flight.
        pa = rand_pd();
        pb = rand_pd();
        pc = rand_pd();
        pd = {34{8'h3C}};
        drive(1'b1, pa, 1'b0);
        tick();
        drive(1'b1, pb, 1'b0);
        tick();
        drive(1'b1, pc, 1'b0);
        tick();
        drive(1'b0, '0, 1'b0);
        check("prerst_rd_pvld", pd_t'(rd_pvld), pd_t'(1'b1));
        #2;
        rst = 1'b1;
        q.delete();
        #1;
        check("async_rd_pvld", pd_t'(rd_pvld), pd_t'(1'b0));
        check("async_count", pd_t'(fifo_count), pd_t'(0));
        check("async_wr_prdy", pd_t'(wr_prdy), pd_t'(1'b1));
        check("async_ram_re", pd_t'(ram_re), pd_t'(1'b0));
        @(posedge clk);
        @(negedge clk);
        rst = 1'b0;
        drive(1'b1, pd, 1'b1);
        tick();
        drive(1'b0, '0, 1'b1);
        pops0 = pops;
        n = 0;
        while ((pops == pops0) && (n < 10)) begin
            tick();
            n++;
        end
        check("postrst_popped", pd_t'(pops - pops0), pd_t'(1));
        check("postrst_first", last_pop, pd);
        drain();

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
